// File: rtl/cdc_clear_sequencer.sv
// CDC clear sequencer: walks one side of the clear handshake
// IDLE -> ISOLATE -> CLEAR -> POST_CLEAR -> IDLE in lockstep with the peer.
module cdc_clear_sequencer #(
  parameter int CLEAR_CYCLES      = 1,
  parameter int POST_CLEAR_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_req_i,
  output logic       busy_o,
  output logic       isolate_o,
  input  logic       isolate_ack_i,
  output logic       clear_o,
  output logic [1:0] phase_o,
  input  logic [1:0] phase_ack_i,
  output logic       done_o
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ISOLATE    = 2'd1;
  localparam logic [1:0] CLEAR      = 2'd2;
  localparam logic [1:0] POST_CLEAR = 2'd3;

  localparam int CW = $clog2(256);
  localparam logic [CW-1:0] CLR_LOAD  = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] POST_LOAD = CW'(POST_CLEAR_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          iso_q, clr_q, done_q;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | clear_req_i;
    unique case (state_q)
      IDLE: begin
        if ((pending_q | clear_req_i) && phase_ack_i == IDLE) begin
          state_d   = ISOLATE;
          // the request that starts a sequence is consumed by it
          pending_d = 1'b0;
        end
      end
      ISOLATE: begin
        if (isolate_ack_i && phase_ack_i == ISOLATE) begin
          state_d = CLEAR;
          cnt_d   = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (cnt_zero && phase_ack_i == CLEAR) begin
          state_d = POST_CLEAR;
          cnt_d   = POST_LOAD;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      POST_CLEAR: begin
        if (cnt_zero && phase_ack_i == POST_CLEAR) begin
          state_d = IDLE;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      iso_q     <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      iso_q     <= (state_d != IDLE);
      clr_q     <= (state_d == CLEAR);
      done_q    <= (state_q == POST_CLEAR) && (state_d == IDLE);
    end
  end

  assign phase_o   = state_q;
  assign isolate_o = iso_q;
  assign clear_o   = clr_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != IDLE) | pending_q;

endmodule
